// File: rtl/cnt_ctrl.sv
// cnt_ctrl: turns three raw active-low push-buttons into the value/format pair
// consumed by the seven-segment display block. Each key is synchronised and
// debounced; inc/dec drive hold-to-repeat FSMs, mode toggles the display format.
// Optional feature macro: CNT_CTRL_AUTO_EN adds i_sw_auto and an auto-increment
// prescaler (AUTO_DIV cycles per step).
module cnt_ctrl #(
    parameter int unsigned DATA_W        = 5,
    parameter int unsigned MAX_VAL       = 31,
    parameter int unsigned DEB_CYCLES    = 250000,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000
`ifdef CNT_CTRL_AUTO_EN
   ,parameter int unsigned AUTO_DIV      = 50000000
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_key_inc,
    input  logic              i_key_dec,
    input  logic              i_key_mode,
`ifdef CNT_CTRL_AUTO_EN
    input  logic              i_sw_auto,
`endif
    output logic [DATA_W-1:0] o_data,
    output logic              o_type
);

    localparam int unsigned NKEY    = 3;
    localparam int unsigned NREP    = 2;
    localparam int unsigned DEB_W   = $clog2(DEB_CYCLES);
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TMR_W   = $clog2(RPT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    // key index: 0 = inc, 1 = dec, 2 = mode
    logic [NKEY-1:0]   w_key_raw;
    logic [NKEY-1:0]   r_sync1;
    logic [NKEY-1:0]   r_sync2;
    logic [NKEY-1:0]   r_acc;
    logic [NKEY-1:0]   r_acc_d;
    logic [DEB_W-1:0]  r_deb_cnt [NKEY];
    logic [NKEY-1:0]   w_press;
    logic [NREP-1:0]   w_step;
    logic              w_auto_step;
    logic [DATA_W-1:0] r_data;
    logic              r_type;
    logic [DATA_W-1:0] w_data_inc;
    logic [DATA_W-1:0] w_data_dec;

    assign w_key_raw = {i_key_mode, i_key_dec, i_key_inc};
    assign w_press   = r_acc_d & ~r_acc;

    // two-flop synchroniser, holding the released level during reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= w_key_raw;
            r_sync2 <= r_sync1;
        end
    end

    // debouncer: accept a new level after DEB_CYCLES consecutive differing samples
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc   <= '1;
            r_acc_d <= '1;
            for (int k = 0; k < NKEY; k++) begin
                r_deb_cnt[k] <= '0;
            end
        end else begin
            r_acc_d <= r_acc;
            for (int k = 0; k < NKEY; k++) begin
                if (r_sync2[k] == r_acc[k]) begin
                    r_deb_cnt[k] <= '0;
                end else if (r_deb_cnt[k] == DEB_W'(DEB_CYCLES - 1)) begin
                    r_acc[k]     <= r_sync2[k];
                    r_deb_cnt[k] <= '0;
                end else begin
                    r_deb_cnt[k] <= r_deb_cnt[k] + DEB_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NREP; g++) begin : g_rep
        rep_state_t       r_state;
        rep_state_t       w_state_nxt;
        logic [TMR_W-1:0] r_tmr;
        logic [TMR_W-1:0] w_tmr_nxt;
        logic             w_step_k;

        // repeat FSM state and hold timer
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_state <= ST_IDLE;
                r_tmr   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_tmr   <= w_tmr_nxt;
            end
        end

        // next state and step decode; release wins over a pending step
        always_comb begin
            w_state_nxt = r_state;
            w_tmr_nxt   = r_tmr + TMR_W'(1);
            w_step_k    = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    w_tmr_nxt = '0;
                    if (w_press[g]) begin
                        w_step_k    = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (r_acc[g]) begin
                        w_state_nxt = ST_IDLE;
                        w_tmr_nxt   = '0;
                    end else if (r_tmr == TMR_W'(REPEAT_DELAY - 1)) begin
                        w_step_k    = 1'b1;
                        w_state_nxt = ST_REPEAT;
                        w_tmr_nxt   = '0;
                    end
                end
                ST_REPEAT: begin
                    if (r_acc[g]) begin
                        w_state_nxt = ST_IDLE;
                        w_tmr_nxt   = '0;
                    end else if (r_tmr == TMR_W'(REPEAT_PERIOD - 1)) begin
                        w_step_k  = 1'b1;
                        w_tmr_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_tmr_nxt   = '0;
                end
            endcase
        end

        assign w_step[g] = w_step_k;
    end

`ifdef CNT_CTRL_AUTO_EN
    localparam int unsigned PSC_W = $clog2(AUTO_DIV + 1);

    logic             r_sw_s1;
    logic             r_sw_s2;
    logic [PSC_W-1:0] r_psc;

    assign w_auto_step = r_sw_s2 && (r_psc == PSC_W'(AUTO_DIV - 1));

    // auto switch synchroniser and prescaler, parked at 0 while the switch is off
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sw_s1 <= 1'b0;
            r_sw_s2 <= 1'b0;
            r_psc   <= '0;
        end else begin
            r_sw_s1 <= i_sw_auto;
            r_sw_s2 <= r_sw_s1;
            if (!r_sw_s2 || w_auto_step) begin
                r_psc <= '0;
            end else begin
                r_psc <= r_psc + PSC_W'(1);
            end
        end
    end
`else
    assign w_auto_step = 1'b0;
`endif

    assign w_data_inc = (r_data >= DATA_W'(MAX_VAL)) ? '0 : r_data + DATA_W'(1);
    assign w_data_dec = (r_data == '0) ? DATA_W'(MAX_VAL) : r_data - DATA_W'(1);

    // counter and format register; key steps override the auto step
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
            r_type <= 1'b0;
        end else begin
            if (w_press[2]) begin
                r_type <= ~r_type;
            end
            case (w_step)
                2'b01:   r_data <= w_data_inc;
                2'b10:   r_data <= w_data_dec;
                2'b11:   r_data <= r_data;
                default: begin
                    if (w_auto_step) begin
                        r_data <= w_data_inc;
                    end
                end
            endcase
        end
    end

    assign o_data = r_data;
    assign o_type = r_type;

endmodule

// File: tb/tb_cnt_ctrl.sv
// tb_cnt_ctrl: directed and randomized stimulus for cnt_ctrl, compared every cycle
// against a behavioural model built from key history windows and press ages.
module tb_cnt_ctrl;

    localparam int DATA_W  = 5;
    localparam int MAX_VAL = 31;
    localparam int DEB     = 4;
    localparam int RD      = 20;
    localparam int RP      = 8;
    localparam int AD      = 10;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [2:0]        keys  = 3'b111;
    logic              sw_auto = 1'b0;
    logic [DATA_W-1:0] o_data;
    logic              o_type;

    cnt_ctrl #(
        .DATA_W        (DATA_W),
        .MAX_VAL       (MAX_VAL),
        .DEB_CYCLES    (DEB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
`ifdef CNT_CTRL_AUTO_EN
       ,.AUTO_DIV      (AD)
`endif
    ) u_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_key_inc  (keys[0]),
        .i_key_dec  (keys[1]),
        .i_key_mode (keys[2]),
`ifdef CNT_CTRL_AUTO_EN
        .i_sw_auto  (sw_auto),
`endif
        .o_data     (o_data),
        .o_type     (o_type)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // behavioural model state
    int         m_edge;
    logic [2:0] m_hist [64];
    logic       m_sw_hist [64];
    logic [2:0] m_acc;
    int         m_press [3];
    int         m_data;
    logic       m_type;
    int         m_sw_run;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, m_edge);
        end
    endtask

    task automatic model_reset();
        m_edge   = 0;
        m_acc    = 3'b111;
        m_data   = 0;
        m_type   = 1'b0;
        m_sw_run = 0;
        for (int k = 0; k < 3; k++) m_press[k] = -1;
    endtask

    function automatic logic raw_at(input logic [1:0] kk, input int e);
        logic [5:0] idx;
        if (e < 1) return 1'b1;
        idx = 6'(e);
        return m_hist[idx][kk];
    endfunction

    function automatic logic sw_at(input int e);
        logic [5:0] idx;
        if (e < 1) return 1'b0;
        idx = 6'(e);
        return m_sw_hist[idx];
    endfunction

    function automatic logic cur_sw();
`ifdef CNT_CTRL_AUTO_EN
        return sw_auto;
`else
        return 1'b0;
`endif
    endfunction

    // a held key steps at press age 0, RD, RD+RP, RD+2*RP, ...
    function automatic logic step_due(input logic [1:0] kk);
        int a;
        if (m_acc[kk] || m_press[kk] < 0) return 1'b0;
        a = m_edge - m_press[kk];
        return (a == 0) || (a >= RD && ((a - RD) % RP) == 0);
    endfunction

    task automatic model_edge();
        logic       s_inc, s_dec, tog, sync_sw, all_diff;
        logic [1:0] kk;
        logic [5:0] idx;
        m_edge++;
        idx = 6'(m_edge);
        m_hist[idx]    = keys;
        m_sw_hist[idx] = cur_sw();
        s_inc = step_due(2'd0);
        s_dec = step_due(2'd1);
        tog   = (m_press[2] == m_edge);
        // accepted level flips once the last DEB synced samples (raw delayed by two) all differ
        for (int k = 0; k < 3; k++) begin
            kk = 2'(k);
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                if (raw_at(kk, m_edge - j - 2) == m_acc[kk]) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_acc[kk]   = ~m_acc[kk];
                m_press[kk] = m_acc[kk] ? -1 : m_edge + 1;
            end
        end
        sync_sw  = sw_at(m_edge - 2);
        m_sw_run = sync_sw ? m_sw_run + 1 : 0;
        if (s_inc && !s_dec)      m_data = (m_data == MAX_VAL) ? 0 : m_data + 1;
        else if (s_dec && !s_inc) m_data = (m_data == 0) ? MAX_VAL : m_data - 1;
        else if (!s_inc && !s_dec && sync_sw && (m_sw_run % AD) == 0)
            m_data = (m_data == MAX_VAL) ? 0 : m_data + 1;
        if (tog) m_type = ~m_type;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        check("o_data", int'(o_data), m_data);
        check("o_type", int'(o_type), int'(m_type));
    endtask

    task automatic do_reset(input int hold);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_async_data", int'(o_data), 0);
        check("rst_async_type", int'(o_type), 0);
        repeat (hold) tick();
        rst_n = 1'b1;
    endtask

    task automatic press(input int k, input int hold);
        keys[2'(k)] = 1'b0;
        repeat (hold) tick();
        keys[2'(k)] = 1'b1;
        repeat (DEB + 6) tick();
    endtask

    initial begin
        int dur [3];
        model_reset();
        repeat (3) tick();
        check("reset_data", int'(o_data), 0);
        check("reset_type", int'(o_type), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) press(0, 10);
        check("five_presses", int'(o_data), 5);

        keys[0] = 1'b0; repeat (3) tick(); keys[0] = 1'b1; repeat (10) tick();
        check("bounce_ignored", int'(o_data), 5);

        keys[0] = 1'b0;
        repeat (6) tick(); check("press_lat_minus1", int'(o_data), 5);
        tick();            check("press_lat", int'(o_data), 6);
        repeat (19) tick(); check("hold_pre_repeat", int'(o_data), 6);
        tick();            check("hold_first_repeat", int'(o_data), 7);
        repeat (3) tick();
        keys[0] = 1'b1;
        repeat (10) tick(); check("release_late_step", int'(o_data), 8);

        keys[0] = 1'b0; repeat (3) tick();
        do_reset(3);
        repeat (6) tick(); check("rst_held_pre", int'(o_data), 0);
        tick();            check("rst_held_press", int'(o_data), 1);
        keys[0] = 1'b1; repeat (10) tick();

        press(1, 10); check("dec_to_zero", int'(o_data), 0);
        press(1, 10); check("wrap_dec", int'(o_data), 31);
        press(0, 10); check("wrap_inc", int'(o_data), 0);

        keys[0] = 1'b0;
        repeat (7) tick();  check("rpt_first", int'(o_data), 1);
        repeat (20) tick(); check("rpt_second", int'(o_data), 2);
        repeat (8) tick();  check("rpt_third", int'(o_data), 3);
        repeat (23) tick();
        keys[0] = 1'b1;
        repeat (14) tick(); check("rpt_total", int'(o_data), 6);

        keys = 3'b000; repeat (10) tick(); keys = 3'b111; repeat (10) tick();
        check("collide_data", int'(o_data), 6);
        check("collide_type", int'(o_type), 1);
        press(2, 10); check("mode_toggle", int'(o_type), 0);

`ifdef CNT_CTRL_AUTO_EN
        sw_auto = 1'b1;
        repeat (11) tick(); check("auto_pre", int'(o_data), 6);
        tick();             check("auto_first", int'(o_data), 7);
        repeat (9) tick();  check("auto_gap", int'(o_data), 7);
        tick();             check("auto_second", int'(o_data), 8);
        repeat (3) tick();
        keys[0] = 1'b0;
        repeat (6) tick();  check("auto_key_pre", int'(o_data), 8);
        tick();             check("auto_key_collide", int'(o_data), 9);
        repeat (3) tick();
        keys[0] = 1'b1;
        repeat (6) tick();  check("auto_after_collide_gap", int'(o_data), 9);
        tick();             check("auto_after_collide", int'(o_data), 10);
        sw_auto = 1'b0;
        repeat (5) tick();
`endif

        for (int k = 0; k < 3; k++) dur[k] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (dur[k] == 0) begin
                    keys[2'(k)] = ~keys[2'(k)];
                    dur[k] = ($urandom_range(1, 0) == 0) ? int'($urandom_range(DEB, 1))
                                                         : int'($urandom_range(80, 1));
                end else begin
                    dur[k]--;
                end
            end
`ifdef CNT_CTRL_AUTO_EN
            if ($urandom_range(199, 0) == 0) sw_auto = ~sw_auto;
`endif
            if ($urandom_range(999, 0) == 0) do_reset(2);
            tick();
        end
        keys = 3'b111;
        sw_auto = 1'b0;
        repeat (DEB + 10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
